// File: rtl/penc_pkg.sv
// Shared types and helpers for the sequential priority encoder:
// state encoding, index-width derivation and the popcount used by PENC_COUNT_EN.
package penc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Index width for an N-bit request vector (N >= 2).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned popcount(input logic [15:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < 16; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/seq_priority_encoder_if.sv
// Request-in / index-out handshake bundle for seq_priority_encoder.
// The cnt signal exists only when PENC_COUNT_EN is defined.
interface seq_priority_encoder_if #(parameter int unsigned N = 4);
  import penc_pkg::*;

  localparam int unsigned W = clog2(N);

  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_bits;
  logic         idx_valid;
  logic         idx_ready;
  logic [W-1:0] idx;
  logic         last;
`ifdef PENC_COUNT_EN
  logic [W:0]   cnt;

  modport master (output req_valid, req_bits, idx_ready,
                  input  req_ready, idx_valid, idx, last, cnt);
  modport slave  (input  req_valid, req_bits, idx_ready,
                  output req_ready, idx_valid, idx, last, cnt);
`else
  modport master (output req_valid, req_bits, idx_ready,
                  input  req_ready, idx_valid, idx, last);
  modport slave  (input  req_valid, req_bits, idx_ready,
                  output req_ready, idx_valid, idx, last);
`endif

endinterface

// File: rtl/lsb_find.sv
// Combinational lowest-set-bit finder: index of the lowest set bit,
// plus flags for "any bit set" and "exactly one bit set".
module lsb_find #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         single
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bits[i] && !found) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves zero only for a one-hot vector.
  assign any    = |bits;
  assign single = any && ((bits & (bits - N'(1))) == '0);

endmodule

// File: rtl/seq_priority_encoder.sv
// Sequential N-to-log2(N) encoder: latches a request vector, then emits the index
// of each set bit lowest first, flagging the last one. Optional cnt via PENC_COUNT_EN.
module seq_priority_encoder
  import penc_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input logic                 clk,
  input logic                 rst,
  seq_priority_encoder_if.slave bus
);

  localparam int unsigned W = clog2(N);

  state_t       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] low_idx;
  logic         pend_any;
  logic         pend_single;

  lsb_find #(.N(N), .W(W)) u_lsb_find (
    .bits   (pend_q),
    .idx    (low_idx),
    .any    (pend_any),
    .single (pend_single)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Next state and outputs; outputs depend on state_q/pend_q only.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    bus.req_ready = 1'b0;
    bus.idx_valid = 1'b0;
    bus.idx       = '0;
    bus.last      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid && (bus.req_bits != '0)) begin
          pend_d  = bus.req_bits;
          state_d = SCAN;
        end
      end
      SCAN: begin
        bus.idx_valid = 1'b1;
        bus.idx       = low_idx;
        bus.last      = pend_single;
        if (bus.idx_ready) begin
          pend_d = pend_q & ~(N'(1) << low_idx);
          if (pend_single || !pend_any) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PENC_COUNT_EN
  logic [W:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && bus.req_valid) begin
      cnt_q <= (W+1)'(popcount(16'(bus.req_bits)));
    end
  end

  assign bus.cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed self-checking bench for seq_priority_encoder (N=4 and N=8 instances).
module tb_seq_priority_encoder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seq_priority_encoder_if #(.N(4)) bus4 ();
  seq_priority_encoder_if #(.N(8)) bus8 ();

  seq_priority_encoder #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  seq_priority_encoder #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat4(input string tag, input int unsigned i, input int unsigned l);
    check({tag, ".valid"}, 32'(bus4.idx_valid), 1);
    check({tag, ".idx"},   32'(bus4.idx), i);
    check({tag, ".last"},  32'(bus4.last), l);
    check({tag, ".ready"}, 32'(bus4.req_ready), 0);
  endtask

  task automatic idle4(input string tag);
    check({tag, ".ready"}, 32'(bus4.req_ready), 1);
    check({tag, ".valid"}, 32'(bus4.idx_valid), 0);
    check({tag, ".idx"},   32'(bus4.idx), 0);
    check({tag, ".last"},  32'(bus4.last), 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus4.req_valid = 1'b0; bus4.req_bits = '0; bus4.idx_ready = 1'b0;
    bus8.req_valid = 1'b0; bus8.req_bits = '0; bus8.idx_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    idle4("reset");
    check("reset8.valid", 32'(bus8.idx_valid), 0);
`ifdef PENC_COUNT_EN
    check("reset.cnt", 32'(bus4.cnt), 0);
`endif

    // Sparse vector 1010
    bus4.idx_ready = 1'b1;
    bus4.req_valid = 1'b1; bus4.req_bits = 4'b1010;
    tick();
    bus4.req_valid = 1'b0;
    beat4("sparse.b0", 1, 0);
    tick();
    beat4("sparse.b1", 3, 1);
    tick();
    idle4("sparse.end");

    // Backpressure on 0111, with a SCAN-time req that must be ignored
    bus4.idx_ready = 1'b0;
    bus4.req_valid = 1'b1; bus4.req_bits = 4'b0111;
    tick();
    bus4.req_bits = 4'b1000;
    beat4("bp.first", 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      beat4("bp.hold", 0, 0);
    end
    bus4.idx_ready = 1'b1;
    tick();
    bus4.req_valid = 1'b0;
    beat4("bp.b1", 1, 0);
    tick();
    beat4("bp.b2", 2, 1);
    tick();
    idle4("bp.end");

    // Zero vector is accepted and dropped
    bus4.req_valid = 1'b1; bus4.req_bits = 4'b0000;
    tick();
    bus4.req_valid = 1'b0;
    idle4("zero.a");
`ifdef PENC_COUNT_EN
    check("zero.cnt", 32'(bus4.cnt), 0);
`endif
    tick();
    idle4("zero.b");

    // Back-to-back batches with req_valid held: one bubble between
    bus4.req_valid = 1'b1; bus4.req_bits = 4'b1000;
    tick();
    bus4.req_bits = 4'b0001;
    beat4("b2b.b0", 3, 1);
    tick();
    idle4("b2b.bubble");
    tick();
    bus4.req_valid = 1'b0;
    beat4("b2b.b1", 0, 1);
    tick();
    idle4("b2b.end");

    // Reset mid-SCAN discards the batch
    bus4.req_valid = 1'b1; bus4.req_bits = 4'b1010;
    tick();
    bus4.req_valid = 1'b0;
    beat4("rst.b0", 1, 0);
    tick();
    beat4("rst.b1", 3, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle4("rst.after");
    bus4.req_valid = 1'b1; bus4.req_bits = 4'b0100;
    tick();
    bus4.req_valid = 1'b0;
    beat4("rst.new", 2, 1);
    tick();
    idle4("rst.end");

    // Reset wins over a simultaneous request
    rst = 1'b1;
    bus4.req_valid = 1'b1; bus4.req_bits = 4'b0001;
    tick();
    rst = 1'b0;
    bus4.req_valid = 1'b0;
    idle4("rstprio");

    // All-ones: 0,1,2,3 on consecutive cycles, last on 3
    bus4.req_valid = 1'b1; bus4.req_bits = 4'b1111;
    tick();
    bus4.req_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      beat4("ones", i, (i == 3) ? 1 : 0);
`ifdef PENC_COUNT_EN
      check("ones.cnt", 32'(bus4.cnt), 4);
`endif
      tick();
    end
    idle4("ones.end");
`ifdef PENC_COUNT_EN
    check("ones.cnt_hold", 32'(bus4.cnt), 4);
    bus4.req_valid = 1'b1; bus4.req_bits = 4'b0110;
    tick();
    bus4.req_valid = 1'b0;
    check("cnt.reload", 32'(bus4.cnt), 2);
    tick(); tick();
`endif

    // N=8 with 8'h81: indices 0 then 7
    bus8.idx_ready = 1'b1;
    bus8.req_valid = 1'b1; bus8.req_bits = 8'h81;
    tick();
    bus8.req_valid = 1'b0;
    check("n8.b0.valid", 32'(bus8.idx_valid), 1);
    check("n8.b0.idx",   32'(bus8.idx), 0);
    check("n8.b0.last",  32'(bus8.last), 0);
    tick();
    check("n8.b1.idx",   32'(bus8.idx), 7);
    check("n8.b1.last",  32'(bus8.last), 1);
    tick();
    check("n8.end.valid", 32'(bus8.idx_valid), 0);
    check("n8.end.ready", 32'(bus8.req_ready), 1);
`ifdef PENC_COUNT_EN
    check("n8.cnt", 32'(bus8.cnt), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_priority_encoder.md
# seq_priority_encoder

Sequential 4-to-2 (parameterised N-to-log2N) encoder: the encoding side of our 2-to-4 one-hot decode path. It accepts a request bit vector over a valid/ready handshake and latches it. It then emits the index of every set bit, lowest index first, one per accepted output beat, and marks the final index of the batch. It sits between request-flag producers and any consumer that needs binary indices, e.g. a downstream 2-to-4 decoder driving one-hot selects.

## Interface
- `N`, default 4: request vector width; legal values 2..16.
- `W`, default 2: index width, equal to clog2(N); derived, not overridden.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: `req_bits` is presented.
- `req_ready` output 1: block can accept a vector (IDLE only).
- `req_bits` input N: request vector; bit i requests index i.
- `idx_valid` output 1: `idx` holds a valid index.
- `idx_ready` input 1: consumer accepts `idx` this cycle.
- `idx` output W: index of the lowest pending set bit.
- `last` output 1: current `idx` is the final pending bit of the batch.
- `cnt` output W+1: number of set bits in the captured vector. Present only with `PENC_COUNT_EN`.

## Operation
- Registers:
  - `state` ∈ {IDLE, SCAN}.
  - `pend[N-1:0]`.
  - `cnt`, when enabled.
- IDLE:
  - `req_ready`=1, `idx_valid`=0.
  - On `req_valid` with `req_bits`≠0: `pend`←`req_bits`, go to SCAN.
  - On `req_valid` with `req_bits`=0: the vector is accepted and dropped; no output beat; stay in IDLE.
- SCAN:
  - `req_ready`=0, `idx_valid`=1.
  - `idx` = position of the lowest set bit of `pend`. Bit 0 has highest priority.
  - `last`=1 when `pend` has exactly one bit set.
- Transfer: a beat transfers when `idx_valid` and `idx_ready` are both 1.
  - On transfer, clear bit `idx` of `pend`.
  - If `last`=1, go to IDLE.
- When `idx_ready`=0:
  - `idx`, `last` and `pend` hold.
  - `idx_valid` stays 1; it is never withdrawn.
- When `idx_valid`=0, `idx`=0 and `last`=0.
- Outputs are decoded only from `state` and `pend`; there is no combinational path from any input to any output.
- Reset, including mid-SCAN:
  - Next edge: `state`=IDLE, `pend`=0, `cnt`=0.
  - Hence `req_ready`=1, `idx_valid`=0, `idx`=0, `last`=0.
  - The in-flight batch is discarded.
- `rst` has priority over every handshake in the same cycle.

## Timing
- Latency: vector accepted at edge t → first `idx_valid` at cycle t+1.
- Throughput: one index per cycle while `idx_ready`=1. A batch of k set bits occupies k cycles of SCAN.
- Batch gap: the final transfer at edge t returns the block to IDLE, so `req_ready`=1 in cycle t+1. That gives one bubble cycle between batches.
- A new vector is never accepted while in SCAN; `req_bits` changes in SCAN are ignored.
- All-ones vector with N=4: indices 0,1,2,3 on four consecutive cycles; `last` asserted on index 3.

## Configuration
- `PENC_COUNT_EN` defined:
  - `cnt` port exists.
  - Loaded with popcount(`req_bits`) on every accepted vector, 0 for a zero vector.
  - Held through SCAN and after return to IDLE until the next acceptance.
  - Reset value 0.
- `PENC_COUNT_EN` undefined: no `cnt` port and no popcount logic. All other behaviour is identical.

## Structure
- Shared package `penc_pkg` contains:
  - State encoding constants: IDLE=1'b0, SCAN=1'b1.
  - The clog2-based `W` derivation function.
  - The popcount function used under `PENC_COUNT_EN`.
- One sub-module, `lsb_find`: combinational N→W lowest-set-bit finder with `any` and `single` (exactly one bit set) outputs. The top instantiates it on `pend`.
- The top holds the FSM, `pend`, `cnt` and the handshake logic.

## Test plan
- Reset mid-SCAN: `req_bits`=4'b1010 accepted, `rst` pulsed after the first index → next cycle `idx_valid`=0, `req_ready`=1; a following 4'b0100 yields `idx`=2, `last`=1.
- Sparse vector: `req_bits`=4'b1010, `idx_ready`=1 → `idx`=1 (`last`=0), then `idx`=3 (`last`=1), then `req_ready`=1.
- Backpressure: `req_bits`=4'b0111, `idx_ready` held 0 for 3 cycles → `idx`=0 stable with `idx_valid`=1; on release, sequence 0,1,2.
- Zero vector: `req_bits`=4'b0000 accepted → `idx_valid` stays 0, `req_ready` stays 1; with `PENC_COUNT_EN`, `cnt`=0.
- Back-to-back batches: 4'b1000 then 4'b0001 with `req_valid` held → `idx`=3 (`last`=1), one bubble cycle, then `idx`=0 (`last`=1).
- `PENC_COUNT_EN` with 4'b1111 → `cnt`=3'd4 from cycle t+1, held until the next accept. Separately, N=8 with `req_bits`=8'h81 → `idx` 0 then 7.
